// File: rtl/spi_job_loader.sv
// Frame assembler behind the SPI shift front-end: collects one job word per chip-select
// window and hands it to the hashing core over valid/ready. CRC-8 check via SPI_JOB_LOADER_CRC_EN.
module spi_job_loader #(
  parameter int JOB_BITS  = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 cs_n_in,
  input  logic                 bit_valid_in,
  input  logic                 bit_in,
  output logic [JOB_BITS-1:0]  job_data_out,
  output logic                 job_valid_out,
  input  logic                 job_ready_in,
  output logic                 busy_out,
  output logic                 frame_err_out,
  output logic                 overrun_out,
  output logic [ERR_CNT_W-1:0] err_count_out
);

  localparam int CNT_W = $clog2(JOB_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(JOB_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(JOB_BITS + 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic [JOB_BITS-1:0] shift_reg;
  logic                start_frame, shift_en, end_frame;
  logic                len_ok, crc_ok, frame_good, frame_bad, commit, overrun;

  always_ff @(posedge clk_in) begin
    if (reset_in) state <= DRAIN;
    else          state <= state_nxt;
  end

  // Reset parks in DRAIN so a frame already in flight is never picked up halfway.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    shift_en    = 1'b0;
    end_frame   = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_n_in) begin
          state_nxt   = RECV;
          start_frame = 1'b1;
        end
      end
      RECV: begin
        if (cs_n_in) begin
          state_nxt = IDLE;
          end_frame = 1'b1;
        end else if (bit_valid_in) begin
          shift_en = 1'b1;
        end
      end
      DRAIN: begin
        if (cs_n_in) state_nxt = IDLE;
      end
      default: state_nxt = DRAIN;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (start_frame) begin
      bit_cnt   <= '0;
      shift_reg <= '0;
    end else if (shift_en) begin
      shift_reg <= {shift_reg[JOB_BITS-2:0], bit_in};
      if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
    end
  end

`ifdef SPI_JOB_LOADER_CRC_EN
  localparam logic [CNT_W-1:0] CNT_PAYLOAD = CNT_W'(JOB_BITS - 8);
  logic [7:0] crc_reg, crc_nxt;

  always_comb crc_nxt = {crc_reg[6:0], 1'b0} ^ ({8{crc_reg[7] ^ bit_in}} & 8'h07);

  always_ff @(posedge clk_in) begin
    if (reset_in || start_frame)                 crc_reg <= 8'h00;
    else if (shift_en && bit_cnt < CNT_PAYLOAD)  crc_reg <= crc_nxt;
  end

  assign crc_ok = (crc_reg == shift_reg[7:0]);
`else
  assign crc_ok = 1'b1;
`endif

  assign len_ok     = (bit_cnt == CNT_FULL);
  assign frame_good = end_frame & len_ok & crc_ok;
  assign frame_bad  = end_frame & ~(len_ok & crc_ok);
  assign commit     = frame_good & (~job_valid_out | job_ready_in);
  assign overrun    = frame_good & job_valid_out & ~job_ready_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      job_data_out  <= '0;
      job_valid_out <= 1'b0;
      frame_err_out <= 1'b0;
      overrun_out   <= 1'b0;
      err_count_out <= '0;
    end else begin
      frame_err_out <= frame_bad;
      overrun_out   <= overrun;
      if (commit) begin
        job_data_out  <= shift_reg;
        job_valid_out <= 1'b1;
      end else if (job_valid_out && job_ready_in) begin
        job_valid_out <= 1'b0;
      end
      if ((frame_bad || overrun) && (err_count_out != '1))
        err_count_out <= err_count_out + 1'b1;
    end
  end

  assign busy_out = (state == RECV);

endmodule

// File: tb/tb_spi_job_loader.sv
// Directed bench for spi_job_loader; inputs change and outputs are checked on the falling edge.
module tb_spi_job_loader;

  localparam int JB = 32;
  localparam int EW = 3;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          cs_n_in = 1'b1;
  logic          bit_valid_in = 1'b0;
  logic          bit_in = 1'b0;
  logic [JB-1:0] job_data_out;
  logic          job_valid_out;
  logic          job_ready_in = 1'b0;
  logic          busy_out;
  logic          frame_err_out;
  logic          overrun_out;
  logic [EW-1:0] err_count_out;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe_base, ov_base;

  spi_job_loader #(.JOB_BITS(JB), .ERR_CNT_W(EW)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .cs_n_in       (cs_n_in),
    .bit_valid_in  (bit_valid_in),
    .bit_in        (bit_in),
    .job_data_out  (job_data_out),
    .job_valid_out (job_valid_out),
    .job_ready_in  (job_ready_in),
    .busy_out      (busy_out),
    .frame_err_out (frame_err_out),
    .overrun_out   (overrun_out),
    .err_count_out (err_count_out)
  );

  always #5 clk_in = ~clk_in;

  // Pulse tallies, sampled at the rising edge so each one-cycle pulse is seen exactly once.
  always @(posedge clk_in) begin
    if (frame_err_out) fe_cnt <= fe_cnt + 1;
    if (overrun_out)   ov_cnt <= ov_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_in = 1'b1; cs_n_in = 1'b1; bit_valid_in = 1'b0; job_ready_in = 1'b0;
    tick(); tick();
    reset_in = 1'b0;
    tick(); tick();
    fe_base = fe_cnt; ov_base = ov_cnt;
  endtask

  task automatic send_bits(input logic [63:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      bit_valid_in = 1'b1;
      bit_in = data[n-1-i];
      tick();
    end
    bit_valid_in = 1'b0;
  endtask

  // Full frame; returns on the falling edge right after the commit edge.
  task automatic frame(input logic [63:0] data, input int n, input logic rdy_end);
    cs_n_in = 1'b0;
    tick();
    send_bits(data, n);
    cs_n_in = 1'b1;
    job_ready_in = rdy_end;
    tick();
  endtask

  initial begin
    do_reset();
    check("rst_valid", job_valid_out, 0);
    check("rst_data", job_data_out, 0);
    check("rst_err", err_count_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_fe", frame_err_out, 0);
    check("rst_ov", overrun_out, 0);

    // Short and long frames
    frame(64'h7FFF_FFFF, 31, 1'b0);
    check("short_pulse", frame_err_out, 1);
    tick();
    frame(64'h1_DEAD_BEEF, 33, 1'b0);
    check("long_pulse", frame_err_out, 1);
    tick(); tick();
    check("len_fe_cnt", fe_cnt - fe_base, 2);
    check("len_valid", job_valid_out, 0);
    check("len_err", err_count_out, 2);

    // Zero-length frames drive the error counter into saturation
    do_reset();
    for (int k = 0; k < 9; k++) begin
      frame(64'h0, 0, 1'b0);
      tick();
    end
    tick();
    check("zero_fe_cnt", fe_cnt - fe_base, 9);
    check("err_sat", err_count_out, 7);
    check("zero_valid", job_valid_out, 0);

`ifndef SPI_JOB_LOADER_CRC_EN
    do_reset();
    frame(64'hDEAD_BEEF, 32, 1'b0);
    check("t1_valid", job_valid_out, 1);
    check("t1_data", job_data_out, 64'hDEAD_BEEF);
    job_ready_in = 1'b1;
    tick();
    job_ready_in = 1'b0;
    check("t1_consumed", job_valid_out, 0);

    do_reset();
    frame(64'h1111_1111, 32, 1'b0);
    tick();
    frame(64'h2222_2222, 32, 1'b0);
    check("ov_pulse", overrun_out, 1);
    check("ov_data", job_data_out, 64'h1111_1111);
    tick(); tick();
    check("ov_cnt", ov_cnt - ov_base, 1);
    check("ov_err", err_count_out, 1);

    // Commit lands on the same edge the held job is consumed
    frame(64'h2222_2222, 32, 1'b1);
    job_ready_in = 1'b0;
    check("swap_valid", job_valid_out, 1);
    check("swap_data", job_data_out, 64'h2222_2222);
    check("swap_ov", overrun_out, 0);
    tick();
    check("swap_hold", job_data_out, 64'h2222_2222);

    // Reset in the middle of a frame
    fe_base = fe_cnt;
    cs_n_in = 1'b0;
    tick();
    send_bits(64'hCAF, 12);
    check("mid_busy", busy_out, 1);
    reset_in = 1'b1;
    tick();
    check("mid_rst_valid", job_valid_out, 0);
    check("mid_rst_data", job_data_out, 0);
    check("mid_rst_err", err_count_out, 0);
    reset_in = 1'b0;
    send_bits(64'hEF00D, 20);
    check("drain_busy", busy_out, 0);
    cs_n_in = 1'b1;
    tick(); tick(); tick();
    check("drain_valid", job_valid_out, 0);
    check("drain_fe", fe_cnt - fe_base, 0);
    check("drain_err", err_count_out, 0);
    frame(64'hCAFE_F00D, 32, 1'b0);
    check("after_valid", job_valid_out, 1);
    check("after_data", job_data_out, 64'hCAFE_F00D);
`else
    do_reset();
    frame(64'h0000_0107, 32, 1'b0);
    check("crc_ok_valid", job_valid_out, 1);
    check("crc_ok_data", job_data_out, 64'h0000_0107);
    job_ready_in = 1'b1;
    tick();
    job_ready_in = 1'b0;
    check("crc_consumed", job_valid_out, 0);
    frame(64'h0000_0108, 32, 1'b0);
    check("crc_bad_pulse", frame_err_out, 1);
    check("crc_bad_valid", job_valid_out, 0);
    tick();
    check("crc_bad_err", err_count_out, 1);
    frame(64'h0000_0000, 32, 1'b0);
    check("crc_zero_valid", job_valid_out, 1);
    check("crc_zero_data", job_data_out, 64'h0);
    check("crc_zero_fe", frame_err_out, 0);
`endif

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
